shift_out_register: RTL and testbench

//  Parallel-in, serial-out unloader: the read-side counterpart of the parallel-load Register.

---
 rtl/shift_out_register.sv | 159 +++++++++++++++
 tb/tb_shift_out_register.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_out_register.sv
// shift_out_register: parallel-in, serial-out unloader.
// Captures an N-bit word on ld and streams it out LSB-first, one bit per
// accepted sout_valid/sout_ready handshake, then pulses done for one cycle.
// Optional feature: define PARITY_EN to append an even-parity bit after the
// data bits. With PARITY_EN undefined the frame is exactly N bits.
//
// Handshake: a bit transfers on a rising clk edge where sout_valid and
// sout_ready are both high. sout_valid never depends on sout_ready, and while
// sout_valid is high without sout_ready, sout and the internal state hold.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=SHIFT, 2=PAR, 3=DONE.
module shift_out_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         ld,
  input  logic         init0,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  // Counter only has to reach N-1, so $clog2(N) bits never wrap early.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  logic             hs;

  // Next-state, datapath updates and outputs, all decoded from the current state.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef PARITY_EN
    par_d      = par_q;
`endif
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    hs         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (init0) begin
          shreg_d = '0;
        end else if (ld) begin
          shreg_d = in;
          cnt_d   = '0;
`ifdef PARITY_EN
          par_d   = ^in;
`endif
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sout_valid = 1'b1;
        sout       = shreg_q[0];
        busy       = 1'b1;
        hs         = sout_ready;
        if (init0) begin
          // Abort: drop the partial word, no done pulse.
          shreg_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (hs) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef PARITY_EN
      S_PAR: begin
        sout_valid = 1'b1;
        sout       = par_q;
        busy       = 1'b1;
        hs         = sout_ready;
        if (init0) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (hs) begin
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        // ld is deliberately ignored here; a new word is only taken from IDLE.
        done    = 1'b1;
        state_d = S_IDLE;
        if (init0) begin
          shreg_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_out_register.sv
// Directed testbench for shift_out_register (N=8). Expected serial streams
// are hand-written tables, first emitted bit leftmost ([0:7] ordering).
// The parity scenario is compiled only when PARITY_EN is defined.
module tb_shift_out_register;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] in;
  logic         ld;
  logic         init0;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_pass;

  shift_out_register #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .ld         (ld),
    .init0      (init0),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock and global timeout.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, sout_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_sout"},  {31'd0, sout},       32'd0);
  endtask

  // Load a word (one-cycle ld), then stream with sout_ready high and compare
  // against seq. Ends in the cycle after the last bit (DONE or PAR).
  task automatic load_word(input logic [N-1:0] word);
    in = word;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    in = '0;
  endtask

  task automatic stream_ready(input string tag, input logic [0:N-1] seq);
    sout_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {31'd0, sout}, {31'd0, seq[i]});
      check($sformatf("%s_v%0d", tag, i), {30'd0, sout_valid, busy}, 32'd3);
      tick();
    end
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"},  {31'd0, done},       32'd1);
    check({tag, "_valid"}, {31'd0, sout_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_state"}, {30'd0, dbg_state},  32'd3);
  endtask

  initial begin
    int cyc;
    int idx;
    logic [0:N-1] seq3;
    logic [3:0]   rdy_pat;

    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    in         = 8'hFF;
    ld         = 1'b1;
    init0      = 1'b0;
    sout_ready = 1'b1;

    // T1: reset for two cycles with ld high.
    tick();
    tick();
    check_idle("t1_rst");
    check("t1_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    ld  = 1'b0;
    in  = '0;
    tick();
    check_idle("t1_after");
    check("t1_state2", {30'd0, dbg_state}, 32'd0);

    // T2: A5 with ready tied high; done exactly one cycle; ld in DONE ignored.
    load_word(8'hA5);
    stream_ready("t2", 8'b10100101);
    expect_done("t2");
    in = 8'hFF;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    check_idle("t2_ld_in_done");
    check("t2_state_idle", {30'd0, dbg_state}, 32'd0);
    tick();
    check_idle("t2_still_idle");

    // T3: 3C with sout_ready pattern 1,0,0,1 repeating.
    seq3    = 8'b00111100;
    rdy_pat = 4'b1001;
    load_word(8'h3C);
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 64) begin
      sout_ready = rdy_pat[3 - (cyc % 4)];
      #1;
      check($sformatf("t3_bit%0d_c%0d", idx, cyc), {31'd0, sout}, {31'd0, seq3[idx]});
      check($sformatf("t3_valid_c%0d", cyc), {31'd0, sout_valid}, 32'd1);
      if (sout_ready) idx++;
      cyc++;
      tick();
    end
    check("t3_bits_sent", idx, N);
    sout_ready = 1'b1;
    expect_done("t3");
    tick();

    // T4: ld of FF during the stream of 0F is ignored.
    load_word(8'h0F);
    sout_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ld = (i == 2);
      in = (i == 2) ? 8'hFF : 8'h00;
      #1;
      check($sformatf("t4_bit%0d", i), {31'd0, sout}, {31'd0, (i < 4)});
      tick();
    end
    ld = 1'b0;
    in = '0;
    expect_done("t4");
    tick();

    // T5: init0 after 3 bits of A5 aborts with no done; fresh ld of 5A works.
    load_word(8'hA5);
    sout_ready = 1'b1;
    check("t5_b0", {31'd0, sout}, 32'd1);
    tick();
    check("t5_b1", {31'd0, sout}, 32'd0);
    tick();
    check("t5_b2", {31'd0, sout}, 32'd1);
    tick();
    init0 = 1'b1;
    tick();
    init0 = 1'b0;
    check_idle("t5_abort");
    check("t5_state", {30'd0, dbg_state}, 32'd0);
    tick();
    check_idle("t5_nodone");
    load_word(8'h5A);
    stream_ready("t5_fresh", 8'b01011010);
    expect_done("t5_fresh");
    tick();

    // Reset mid-stream: partial word discarded, no done.
    load_word(8'hC3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid");
    tick();
    check_idle("rst_mid_nodone");

`ifdef PARITY_EN
    // T6: parity bit after data; done one cycle later than without parity.
    load_word(8'h07);
    stream_ready("t6a", 8'b11100000);
    check("t6a_par", {31'd0, sout}, 32'd1);
    check("t6a_par_v", {30'd0, sout_valid, busy}, 32'd3);
    tick();
    expect_done("t6a");
    tick();
    load_word(8'h03);
    stream_ready("t6b", 8'b11000000);
    check("t6b_par", {31'd0, sout}, 32'd0);
    check("t6b_par_v", {30'd0, sout_valid, busy}, 32'd3);
    tick();
    expect_done("t6b");
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
